// File: rtl/prince_inv_slayer_serial.sv
// Serial PRINCE inverse S-layer: accepts one 64-bit state, substitutes NPC
// nibbles per cycle, then holds the result until the consumer takes it.
module prince_inv_slayer_serial #(
    parameter int NPC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);
    localparam int NG = 16 / NPC;
    localparam int CW = (NPC == 16) ? 1 : $clog2(NG);
    localparam logic [CW-1:0] LAST_GRP = CW'(NG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [63:0]   work_reg, work_next;
    logic [63:0]   work_sub;
    logic          accept;
    logic          last_grp;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0:    inv_sbox = 4'hB;
            4'h1:    inv_sbox = 4'h7;
            4'h2:    inv_sbox = 4'h3;
            4'h3:    inv_sbox = 4'h2;
            4'h4:    inv_sbox = 4'hF;
            4'h5:    inv_sbox = 4'hD;
            4'h6:    inv_sbox = 4'h8;
            4'h7:    inv_sbox = 4'h9;
            4'h8:    inv_sbox = 4'hA;
            4'h9:    inv_sbox = 4'h6;
            4'hA:    inv_sbox = 4'h4;
            4'hB:    inv_sbox = 4'h0;
            4'hC:    inv_sbox = 4'h5;
            4'hD:    inv_sbox = 4'hE;
            4'hE:    inv_sbox = 4'hC;
            default: inv_sbox = 4'h1;
        endcase
    endfunction

    assign accept   = in_valid && (state_reg == IDLE);
    assign last_grp = (cnt_reg == LAST_GRP);

    // Each nibble is substituted only while the counter points at its group.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_nib
            localparam logic [CW-1:0] GRP = CW'(gi / NPC);
            assign work_sub[4*gi +: 4] = (cnt_reg == GRP) ? inv_sbox(work_reg[4*gi +: 4])
                                                          : work_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_grp)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            work_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            work_reg <= work_next;
        end
    end

    // Counter saturates on the final group so it never wraps.
    always_comb begin
        cnt_next  = cnt_reg;
        work_next = work_reg;
        if (accept) begin
            work_next = data_in;
            cnt_next  = '0;
        end else if (state_reg == BUSY) begin
            work_next = work_sub;
            if (!last_grp) begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    assign data_out = work_reg;

endmodule

// File: tb/tb_prince_inv_slayer_serial.sv
// Scoreboard bench: five instances (NPC = 1,2,4,8,16) checked against a
// table-driven nibble model; instance 2 (NPC=4) also gets backpressure and reset.
module tb_prince_inv_slayer_serial;
    localparam int NI = 5;
    localparam logic [3:0] INV_TBL [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                             4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
    localparam logic [3:0] FWD_TBL [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                             4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [63:0] data_in   [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [63:0] data_out  [NI];
    logic        busy      [NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] stim_mem [NI][64];
    int          stim_wr  [NI];
    int          done_cnt [NI];
    int          aborted  [NI];
    logic        hold     [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] inv_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = INV_TBL[x[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [63:0] fwd_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = FWD_TBL[x[4*i +: 4]];
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int NPC = 1 << gi;
            localparam int LAT = 16 / NPC;
            exp_t exp_q[$];

            prince_inv_slayer_serial #(.NPC(NPC)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .data_in   (data_in[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .data_out  (data_out[gi]),
                .busy      (busy[gi])
            );

            initial begin : drv
                int rd;
                rd = 0;
                in_valid[gi] = 1'b0;
                data_in[gi]  = '0;
                forever begin
                    @(negedge clk);
                    if (rst_n && rd < stim_wr[gi]) begin
                        in_valid[gi] = 1'b1;
                        data_in[gi]  = stim_mem[gi][rd];
                        if (in_ready[gi]) begin
                            exp_q.push_back('{stim_mem[gi][rd], inv_layer(stim_mem[gi][rd]), cyc + 1});
                            rd++;
                            @(posedge clk);
                            #1;
                            in_valid[gi] = 1'b0;
                            data_in[gi]  = {$urandom, $urandom};
                        end
                    end
                end
            end

            initial begin : mon
                logic        seen;
                logic        prev_v;
                logic [63:0] prev;
                int          first;
                exp_t        e;
                seen = 1'b0; prev_v = 1'b0; prev = '0; first = 0;
                out_ready[gi] = 1'b0;
                done_cnt[gi]  = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        exp_q.delete();
                        seen = 1'b0;
                        prev_v = 1'b0;
                        checks++;
                        if (out_valid[gi] || busy[gi] || !in_ready[gi] || data_out[gi] != 64'h0) begin
                            errors++;
                            $display("FAIL reset_state npc=%0d: ov=%b busy=%b ir=%b dout=%h, required 0/0/1/0",
                                     NPC, out_valid[gi], busy[gi], in_ready[gi], data_out[gi]);
                        end
                    end else begin
                        out_ready[gi] = hold[gi] ? 1'b0 : ($urandom_range(0, 3) != 0);
                        if (out_valid[gi]) begin
                            if (!seen) begin
                                seen = 1'b1;
                                first = cyc;
                                checks++;
                                if (exp_q.size() == 0) begin
                                    errors++;
                                    $display("FAIL unexpected_out npc=%0d: out_valid=1 dout=%h, required no output",
                                             NPC, data_out[gi]);
                                end
                            end
                            if (prev_v) begin
                                checks++;
                                if (data_out[gi] != prev) begin
                                    errors++;
                                    $display("FAIL hold_data npc=%0d: dout=%h, required %h", NPC, data_out[gi], prev);
                                end
                            end
                            if (out_ready[gi]) begin
                                if (exp_q.size() != 0) begin
                                    e = exp_q.pop_front();
                                    checks += 2;
                                    if (data_out[gi] != e.exp) begin
                                        errors++;
                                        $display("FAIL data npc=%0d: in=%h dout=%h, required %h",
                                                 NPC, e.din, data_out[gi], e.exp);
                                    end
                                    if (first - e.acc != LAT) begin
                                        errors++;
                                        $display("FAIL latency npc=%0d: got %0d, required %0d",
                                                 NPC, first - e.acc, LAT);
                                    end
                                    $display("txn npc=%0d in=%h out=%h exp=%h lat=%0d",
                                             NPC, e.din, data_out[gi], e.exp, first - e.acc);
                                end
                                done_cnt[gi]++;
                                seen = 1'b0;
                                prev_v = 1'b0;
                            end else begin
                                prev_v = 1'b1;
                                prev = data_out[gi];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic push(input int k, input logic [63:0] v);
        stim_mem[k][stim_wr[k]] = v;
        stim_wr[k]++;
    endtask

    task automatic wait_drain(input int k);
        int t;
        t = 0;
        while (done_cnt[k] < stim_wr[k] - aborted[k] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL drain_timeout inst=%0d: done %0d, required %0d", k, done_cnt[k], stim_wr[k] - aborted[k]);
        end
    endtask

    task automatic wait_sig(input int k, input bit want_busy, input string name);
        int t;
        t = 0;
        while (!(want_busy ? busy[k] : out_valid[k]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL %s_timeout inst=%0d: signal never rose, required high", name, k);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] r, v1;
        for (int k = 0; k < NI; k++) begin
            stim_wr[k] = 0;
            aborted[k] = 0;
            hold[k]    = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors plus random ones (half as round trips) on every NPC.
        for (int k = 0; k < NI; k++) begin
            push(k, 64'h0000000000000000);
            push(k, 64'h0123456789ABCDEF);
            push(k, 64'hBF32AC916780E5D4);
            for (int j = 0; j < 8; j++) begin
                r = {$urandom, $urandom};
                push(k, ($urandom_range(0, 1) != 0) ? fwd_layer(r) : r);
            end
        end
        for (int k = 0; k < NI; k++) wait_drain(k);

        // Backpressure on NPC=4: output must hold and a new request must wait.
        hold[2] = 1'b1;
        v1 = {$urandom, $urandom};
        push(2, v1);
        wait_sig(2, 1'b0, "bp_out_valid");
        push(2, {$urandom, $urandom});
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (!out_valid[2] || in_ready[2] || busy[2] || data_out[2] != inv_layer(v1)) begin
                errors++;
                $display("FAIL backpressure cycle %0d: ov=%b ir=%b busy=%b dout=%h, required 1/0/0/%h",
                         j, out_valid[2], in_ready[2], busy[2], data_out[2], inv_layer(v1));
            end
        end
        hold[2] = 1'b0;
        wait_drain(2);

        // Reset in BUSY with cnt=2: operation is discarded.
        push(2, {$urandom, $urandom});
        wait_sig(2, 1'b1, "busy");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        aborted[2]++;
        #1;
        checks++;
        if (out_valid[2] || busy[2] || !in_ready[2] || data_out[2] != 64'h0) begin
            errors++;
            $display("FAIL reset_immediate: ov=%b busy=%b ir=%b dout=%h, required 0/0/1/0",
                     out_valid[2], busy[2], in_ready[2], data_out[2]);
        end
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid[2]) begin
                errors++;
                $display("FAIL post_reset_no_output cycle %0d: out_valid=%b, required 0", j, out_valid[2]);
            end
        end
        push(2, 64'hFFFFFFFFFFFFFFFF);
        wait_drain(2);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
